// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic phase sequencer: FSM state codes,
// light codes driven on the street outputs, and street identifiers used
// to remember which street held green most recently.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_AG   = 3'd0,
        S_AY   = 3'd1,
        S_AR   = 3'd2,
        S_BG   = 3'd3,
        S_BY   = 3'd4,
        S_BR   = 3'd5,
        S_WALK = 3'd6
    } state_t;

    localparam logic [1:0] LIGHT_RED    = 2'd0;
    localparam logic [1:0] LIGHT_YELLOW = 2'd1;
    localparam logic [1:0] LIGHT_GREEN  = 2'd2;

    localparam logic STREET_A = 1'b0;
    localparam logic STREET_B = 1'b1;

endpackage

// File: rtl/phase_timer.sv
// Dwell counter for one phase: clears on phase change, counts while not held,
// optionally saturates at target-1. o_expired flags cnt == target-1.
// Ports: i_clk/i_rst, i_clear, i_hold, i_target, i_saturate -> o_cnt, o_expired.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_hold,
    input  logic [CNT_W-1:0] i_target,
    input  logic             i_saturate,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign o_cnt     = cnt_q;
    assign o_expired = (cnt_q == (i_target - CNT_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (!i_hold && !(i_saturate && o_expired)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-street intersection phase controller with one pedestrian crossing.
// Dwell timing is internal; lights/walk decode from the state register and
// o_phase_done pulses in the first cycle of each new state.
// Ports: i_clk, i_rst (async high), i_car_a/b, i_ped_req, i_hold ->
//        o_l_a, o_l_b, o_walk, o_ped_pending, o_state, o_phase_done.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int T_GREEN_MIN = 10,
    parameter int T_GREEN_MAX = 30,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 1,
    parameter int T_WALK      = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_car_a,
    input  logic       i_car_b,
    input  logic       i_ped_req,
    input  logic       i_hold,
    output logic [1:0] o_l_a,
    output logic [1:0] o_l_b,
    output logic       o_walk,
    output logic       o_ped_pending,
    output logic [2:0] o_state,
    output logic       o_phase_done
);

    localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(T_GREEN_MIN - 1);

    state_t           state_q, state_d;
    logic             ped_q, ped_d;
    logic             last_green_q, last_green_d;
    logic             phase_done_q;
    logic             state_change;
    logic [CNT_W-1:0] tgt;
    logic             sat;
    logic [CNT_W-1:0] cnt;
    logic             expired;

    // Greens run against the max-dwell target and saturate there, so
    // "expired" in a green state means the max-green limit has been reached.
    always_comb begin
        tgt = CNT_W'(T_GREEN_MAX);
        sat = 1'b0;
        unique case (state_q)
            S_AG, S_BG: begin tgt = CNT_W'(T_GREEN_MAX); sat = 1'b1; end
            S_AY, S_BY: tgt = CNT_W'(T_YELLOW);
            S_AR, S_BR: tgt = CNT_W'(T_ALLRED);
            S_WALK:     tgt = CNT_W'(T_WALK);
            default:    tgt = CNT_W'(T_GREEN_MAX);
        endcase
    end

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (state_change),
        .i_hold     (i_hold),
        .i_target   (tgt),
        .i_saturate (sat),
        .o_cnt      (cnt),
        .o_expired  (expired)
    );

    always_comb begin
        state_d      = state_q;
        last_green_d = last_green_q;
        case (state_q)
            S_AG: if (!i_hold && cnt >= GMIN_M1 &&
                      (ped_q || (i_car_b && (!i_car_a || expired)))) begin
                state_d      = S_AY;
                last_green_d = STREET_A;
            end
            S_BG: if (!i_hold && cnt >= GMIN_M1 &&
                      (ped_q || (i_car_a && (!i_car_b || expired)))) begin
                state_d      = S_BY;
                last_green_d = STREET_B;
            end
            S_AY:   if (!i_hold && expired) state_d = S_AR;
            S_BY:   if (!i_hold && expired) state_d = S_BR;
            S_AR:   if (!i_hold && expired) state_d = ped_q ? S_WALK : S_BG;
            S_BR:   if (!i_hold && expired) state_d = ped_q ? S_WALK : S_AG;
            S_WALK: if (!i_hold && expired)
                state_d = (last_green_q == STREET_A) ? S_BG : S_AG;
            default: state_d = S_AG;  // illegal encoding recovers immediately
        endcase
    end

    assign state_change = (state_d != state_q);

    // Entering WALK consumes the request; a press in that same cycle is absorbed.
    always_comb begin
        ped_d = ped_q;
        if (state_d == S_WALK && state_q != S_WALK) begin
            ped_d = 1'b0;
        end else if (state_q != S_WALK && i_ped_req) begin
            ped_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_AG;
            ped_q        <= 1'b0;
            last_green_q <= STREET_A;
            phase_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ped_q        <= ped_d;
            last_green_q <= last_green_d;
            phase_done_q <= state_change;
        end
    end

    assign o_l_a         = (state_q == S_AG) ? LIGHT_GREEN :
                           (state_q == S_AY) ? LIGHT_YELLOW : LIGHT_RED;
    assign o_l_b         = (state_q == S_BG) ? LIGHT_GREEN :
                           (state_q == S_BY) ? LIGHT_YELLOW : LIGHT_RED;
    assign o_walk        = (state_q == S_WALK);
    assign o_ped_pending = ped_q;
    assign o_state       = state_q;
    assign o_phase_done  = phase_done_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench: a phase/dwell reference model predicts the outputs after
// each clock edge and queues them; a monitor compares every cycle.
module tb_traffic_phase_sequencer;

    localparam int GMIN = 10, GMAX = 30, TY = 3, TAR = 1, TW = 8;
    localparam int P_AG = 0, P_AY = 1, P_AR = 2, P_BG = 3, P_BY = 4, P_BR = 5, P_WK = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       car_a = 1'b0, car_b = 1'b0, ped_req = 1'b0, hold = 1'b0;
    logic [1:0] l_a, l_b;
    logic       walk, ped_pending, phase_done;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] la;
        logic [1:0] lb;
        logic       walk;
        logic       ped;
        logic [2:0] st;
        logic       pd;
    } exp_t;

    exp_t exp_q[$];

    traffic_phase_sequencer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_car_a       (car_a),
        .i_car_b       (car_b),
        .i_ped_req     (ped_req),
        .i_hold        (hold),
        .o_l_a         (l_a),
        .o_l_b         (l_b),
        .o_walk        (walk),
        .o_ped_pending (ped_pending),
        .o_state       (state),
        .o_phase_done  (phase_done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_ph   = P_AG;   // current phase
    int m_done = 0;      // unheld cycles already served in this phase
    bit m_ped  = 0;
    bit m_last_a = 1;    // street A held green most recently
    bit m_pd   = 0;

    function automatic int dwell(input int ph);
        case (ph)
            P_AY, P_BY: return TY;
            P_AR, P_BR: return TAR;
            default:    return TW;
        endcase
    endfunction

    function automatic int after_fixed(input int ph, input bit ped, input bit last_a);
        case (ph)
            P_AY:    return P_AR;
            P_BY:    return P_BR;
            P_AR:    return ped ? P_WK : P_BG;
            P_BR:    return ped ? P_WK : P_AG;
            default: return last_a ? P_BG : P_AG;
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit ca, input bit cb, input bit pr, input bit h);
        int  nxt;
        int  served;
        bit  mine, other;
        if (r) begin
            m_ph = P_AG; m_done = 0; m_ped = 0; m_last_a = 1; m_pd = 0;
            return;
        end
        nxt    = m_ph;
        served = m_done + 1;
        if (!h) begin
            if (m_ph == P_AG || m_ph == P_BG) begin
                mine  = (m_ph == P_AG) ? ca : cb;
                other = (m_ph == P_AG) ? cb : ca;
                if (served >= GMIN && (m_ped || (other && (!mine || served >= GMAX))))
                    nxt = m_ph + 1;
            end else if (served >= dwell(m_ph)) begin
                nxt = after_fixed(m_ph, m_ped, m_last_a);
            end
        end
        if (nxt == P_AY) m_last_a = 1;
        if (nxt == P_BY) m_last_a = 0;
        if (nxt == P_WK && m_ph != P_WK) m_ped = 0;
        else if (m_ph != P_WK && pr)     m_ped = 1;
        m_pd   = (nxt != m_ph);
        m_done = (nxt != m_ph) ? 0 : (h ? m_done : m_done + 1);
        m_ph   = nxt;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.la   = (m_ph == P_AG) ? 2'd2 : (m_ph == P_AY) ? 2'd1 : 2'd0;
        e.lb   = (m_ph == P_BG) ? 2'd2 : (m_ph == P_BY) ? 2'd1 : 2'd0;
        e.walk = (m_ph == P_WK);
        e.ped  = m_ped;
        e.st   = 3'(m_ph);
        e.pd   = m_pd;
        return e;
    endfunction

    // One clock: inputs change on the falling edge, prediction for the
    // following rising edge goes to the scoreboard.
    task automatic step(input bit r, input bit ca, input bit cb, input bit pr, input bit h);
        @(negedge clk);
        rst = r; car_a = ca; car_b = cb; ped_req = pr; hold = h;
        model_edge(r, ca, cb, pr, h);
        exp_q.push_back(model_out());
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({l_a, l_b, walk, ped_pending, state, phase_done} !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got la=%0d lb=%0d walk=%0b ped=%0b st=%0d pd=%0b exp la=%0d lb=%0d walk=%0b ped=%0b st=%0d pd=%0b",
                             $time, l_a, l_b, walk, ped_pending, state, phase_done,
                             e.la, e.lb, e.walk, e.ped, e.st, e.pd);
                end
                checks++;
                if ((l_a != 2'd0 && l_b != 2'd0) || (walk && (l_a != 2'd0 || l_b != 2'd0))) begin
                    errors++;
                    $display("FAIL safety t=%0t got la=%0d lb=%0d walk=%0b exp conflict-free lights",
                             $time, l_a, l_b, walk);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit ca, cb;
        bit found;

        // 1: A traffic only, rests in A green
        do_reset();
        for (int i = 0; i < 100; i++) step(0, 1, 0, 0, 0);

        // 2: B traffic only, hands over and rests in B green
        do_reset();
        for (int i = 0; i < 40; i++) step(0, 0, 1, 0, 0);

        // 3: both streets busy, max-green alternation
        do_reset();
        for (int i = 0; i < 150; i++) step(0, 1, 1, 0, 0);

        // 4: no cars, single pedestrian press at cycle 2
        do_reset();
        for (int i = 0; i < 40; i++) step(0, 0, 0, (i == 2), 0);

        // 5: hold five cycles from the second cycle of A yellow, press during hold
        do_reset();
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_ph == P_AY && m_done == 1) found = 1;
            else step(0, 0, 1, 0, 0);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL hold_setup got no_AY exp AY_reached");
        end
        for (int i = 0; i < 5; i++) step(0, 0, 1, (i == 2), 1);
        for (int i = 0; i < 30; i++) step(0, 0, 1, 0, 0);

        // 6: reset pulse during WALK with a fresh press
        do_reset();
        found = 0;
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_ph == P_WK) found = 1;
            else step(0, 0, 0, 0, 0);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL walk_setup got no_WALK exp WALK_reached");
        end
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 40; i++) step(0, 1, 1, 0, 0);

        // random traffic, presses, holds and occasional resets
        ca = 0; cb = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) ca = ~ca;
            if ($urandom_range(0, 15) == 0) cb = ~cb;
            step(($urandom_range(0, 799) == 0), ca, cb,
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0));
        end

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
Timed phase controller for a two-street intersection with one pedestrian crossing.
- Decides when each street's light changes, using per-phase dwell timers, vehicle-presence sensors and a latched pedestrian request.
- Drives light codes for street A and street B plus a walk signal.
- Sits above the light-decode logic and replaces externally supplied timer-expiry inputs with internally generated timing.

Parameters:
CNT_W, 8, width of the dwell counter
T_GREEN_MIN, 10, minimum green dwell in cycles (>=1)
T_GREEN_MAX, 30, maximum green dwell in cycles when the cross street is waiting (>=T_GREEN_MIN, <2^CNT_W)
T_YELLOW, 3, yellow dwell in cycles (>=1)
T_ALLRED, 1, all-red clearance dwell in cycles (>=1)
T_WALK, 8, pedestrian walk dwell in cycles (>=1)

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous, active-high reset
i_car_a  input  1  vehicle present on street A (level)
i_car_b  input  1  vehicle present on street B (level)
i_ped_req  input  1  pedestrian button, sampled each cycle
i_hold  input  1  maintenance hold: freeze timer and state
o_l_a  output  2  street A light: 0 RED, 1 YELLOW, 2 GREEN
o_l_b  output  2  street B light, same encoding
o_walk  output  1  pedestrian walk lamp
o_ped_pending  output  1  latched pedestrian request
o_state  output  3  current state encoding (debug)
o_phase_done  output  1  one-cycle pulse in first cycle of each new state

Behaviour:
- One clock, i_clk; reset i_rst is asynchronous and active-high. All state is in registers cleared by i_rst.
- Reset values: state=S_AG, cnt=0, ped_pending=0, last_green=A, o_phase_done=0. Outputs during reset: o_l_a=2, o_l_b=0, o_walk=0, o_ped_pending=0.
- States: S_AG=0, S_AY=1, S_AR=2, S_BG=3, S_BY=4, S_BR=5, S_WALK=6. Encoding 7 is illegal and goes to S_AG on the next edge.
- Light and walk outputs decode combinationally from the state register.
  - A lights: S_AG=GREEN, S_AY=YELLOW, all other states RED.
  - B lights: S_BG=GREEN, S_BY=YELLOW, all other states RED.
  - o_walk=1 only in S_WALK.
- Dwell counter cnt:
  - Cleared to 0 on every state change.
  - Otherwise increments by 1 per cycle while i_hold=0.
  - Saturates at T_GREEN_MAX-1 in the green states.
- Fixed-dwell states (AY, BY, AR, BR, WALK) exit when cnt==T-1 and i_hold=0, so each lasts exactly T cycles when no hold is applied.
- S_AG exits to S_AY when cnt>=T_GREEN_MIN-1, i_hold=0, and either:
  - ped_pending=1, or
  - i_car_b=1 and (i_car_a=0 or cnt==T_GREEN_MAX-1).
- If neither condition holds, S_AG rests in green indefinitely.
- S_BG is symmetric, using i_car_a and exiting to S_BY.
- S_AY -> S_AR. S_BY -> S_BR.
- S_AR -> S_WALK if ped_pending, else S_BG. S_BR -> S_WALK if ped_pending, else S_AG.
- last_green is set to A on entry to S_AY and to B on entry to S_BY.
- S_WALK -> S_BG if last_green=A, else S_AG.
- ped_pending:
  - Set when i_ped_req=1 in any state except S_WALK.
  - Cleared on the edge that enters S_WALK; a request in that same cycle is absorbed, not re-latched.
  - Requests during S_WALK are ignored.
- i_hold=1: no state change and cnt frozen. ped_pending still latches. Hold applies in every state, including mid-transition decisions.
- o_phase_done is registered: 1 for exactly the first cycle after any state change, 0 otherwise.
- Safety invariants:
  - Never both o_l_a!=0 and o_l_b!=0.
  - o_walk=1 implies o_l_a=0 and o_l_b=0.
  - Every GREEN->GREEN handover passes through YELLOW then all-red.
- Reset asserted mid-operation (any state) returns immediately to reset values; in-flight requests are lost.

Decomposition:
- Package traffic_pkg:
  - State encodings S_AG..S_WALK.
  - Light codes LIGHT_RED=0, LIGHT_YELLOW=1, LIGHT_GREEN=2.
  - Street identifier constants STREET_A/STREET_B.
- Sub-module phase_timer:
  - Inputs: clear, hold, target, saturate.
  - Outputs: cnt and expired (cnt==target-1).
  - Instantiated once. The FSM, ped latch and output decode stay in the top module.

Test Plan:
1. Reset, i_car_a=1, i_car_b=0, no ped -> stays S_AG for 100 cycles; o_l_a=2, o_l_b=0, o_phase_done never pulses.
2. i_car_a=0, i_car_b=1 from reset release -> o_phase_done at cycles 10, 13 and 14 (AY, AR, BG entry); o_l_b=2 from cycle 14; BG rests while i_car_a=0.
3. i_car_a=i_car_b=1 continuously -> AG 30 cycles, AY 3, AR 1, BG 30, BY 3, BR 1, repeating; assert both safety invariants every cycle.
4. No cars, one-cycle i_ped_req at cycle 2 -> o_ped_pending=1 from cycle 3; AY at 10; WALK at 14 for 8 cycles with o_walk=1 and both lights RED; ped_pending=0 at cycle 14; next state S_BG at 22.
5. i_hold=1 for 5 cycles starting in 2nd cycle of S_AY -> AY lasts 8 cycles; i_ped_req pulsed during hold gives o_ped_pending=1 and the following all-red goes to S_WALK.
6. i_rst pulsed for 1 cycle during S_WALK with ped_pending re-requested -> immediately o_l_a=2, o_walk=0, o_ped_pending=0, o_state=0; normal sequencing resumes after release.
